// File: rtl/mp_mem_arbiter_pkg.sv
// Shared mp_ constants: FSM encoding, line geometry and parameter defaults
// for the I$/D$ memory arbiter.
package mp_mem_arbiter_pkg;

   localparam int MP_BEATS   = 4;
   localparam int MP_TIMEOUT = 255;
   localparam int MP_ADDR_W  = 16;
   localparam int MP_BEAT_W  = 32;
   localparam int MP_LINE_W  = 128;

   // Owner encoding doubles as the round-robin "last granted" value.
   localparam logic MP_OWN_IC = 1'b0;
   localparam logic MP_OWN_DC = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_BEAT = 2'd2,
      ST_RESP = 2'd3
   } mp_state_e;

endpackage

// File: rtl/mp_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side
// that was not granted last. Grant is one-hot, or zero with no request.
module mp_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mp_mem_arbiter.sv
// Arbitrates I$ fills and D$ fills/writebacks onto a single beat-based memory
// bus, with a watchdog that completes a stalled transaction with err.
module mp_mem_arbiter
   import mp_mem_arbiter_pkg::*;
#(
   parameter int BEATS   = MP_BEATS,
   parameter int TIMEOUT = MP_TIMEOUT
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 ic_req,
   input  logic [MP_ADDR_W-1:0] ic_addr,
   output logic                 ic_done,
   input  logic                 dc_req,
   input  logic                 dc_rwn,
   input  logic [MP_ADDR_W-1:0] dc_addr,
   input  logic [MP_LINE_W-1:0] dc_wdata,
   output logic                 dc_done,
   output logic [MP_LINE_W-1:0] line_rdata,
   output logic                 err,
   output logic                 bus_req,
   input  logic                 bus_gnt,
   output logic                 bus_rwn,
   output logic [MP_ADDR_W-1:0] bus_addr,
   input  logic                 bus_beat,
   output logic [MP_BEAT_W-1:0] bus_wdata,
   input  logic [MP_BEAT_W-1:0] bus_rdata
);

   localparam int CNT_W = $clog2(BEATS);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   mp_state_e            state_q;
   logic                 owner_q;
   logic                 rwn_q;
   logic                 last_q;
   logic [MP_ADDR_W-1:0] addr_q;
   logic [MP_LINE_W-1:0] buf_q;
   logic [MP_LINE_W-1:0] buf_d;
   logic [MP_LINE_W-1:0] line_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [WD_W-1:0]      wdog_q;
   logic                 bus_req_q;
   logic                 ic_done_q;
   logic                 dc_done_q;
   logic                 err_q;
   logic [1:0]           grant;
   logic                 wd_hit;

   mp_rr_arb2 u_rr (
      .req   ({dc_req, ic_req}),
      .last  (last_q),
      .grant (grant)
   );

   assign wd_hit = (wdog_q == WD_W'(TIMEOUT));

   // Buffer contents including the beat arriving this cycle, so the last
   // read beat lands in line_rdata on the same edge that raises done.
   always_comb begin
      buf_d = buf_q;
      if (rwn_q) buf_d[MP_BEAT_W*cnt_q +: MP_BEAT_W] = bus_rdata;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= MP_OWN_IC;
         rwn_q     <= 1'b1;
         last_q    <= MP_OWN_DC;
         addr_q    <= '0;
         buf_q     <= '0;
         line_q    <= '0;
         cnt_q     <= '0;
         wdog_q    <= '0;
         bus_req_q <= 1'b0;
         ic_done_q <= 1'b0;
         dc_done_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ic_done_q <= 1'b0;
         dc_done_q <= 1'b0;
         err_q     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|grant) begin
                  owner_q   <= grant[1];
                  rwn_q     <= grant[1] ? dc_rwn : 1'b1;
                  addr_q    <= grant[1] ? dc_addr : ic_addr;
                  if (grant[1] && !dc_rwn) buf_q <= dc_wdata;
                  wdog_q    <= '0;
                  bus_req_q <= 1'b1;
                  state_q   <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (bus_gnt) begin
                  bus_req_q <= 1'b0;
                  cnt_q     <= '0;
                  wdog_q    <= '0;
                  state_q   <= ST_BEAT;
               end else if (wd_hit) begin
                  bus_req_q <= 1'b0;
                  line_q    <= '0;
                  err_q     <= 1'b1;
                  ic_done_q <= (owner_q == MP_OWN_IC);
                  dc_done_q <= (owner_q == MP_OWN_DC);
                  state_q   <= ST_RESP;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            ST_BEAT: begin
               if (bus_beat) begin
                  buf_q  <= buf_d;
                  cnt_q  <= cnt_q + 1'b1;
                  wdog_q <= '0;
                  if (cnt_q == CNT_W'(BEATS - 1)) begin
                     line_q    <= buf_d;
                     ic_done_q <= (owner_q == MP_OWN_IC);
                     dc_done_q <= (owner_q == MP_OWN_DC);
                     state_q   <= ST_RESP;
                  end
               end else if (wd_hit) begin
                  line_q    <= '0;
                  err_q     <= 1'b1;
                  ic_done_q <= (owner_q == MP_OWN_IC);
                  dc_done_q <= (owner_q == MP_OWN_DC);
                  state_q   <= ST_RESP;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            ST_RESP: begin
               last_q  <= owner_q;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ic_done    = ic_done_q;
   assign dc_done    = dc_done_q;
   assign err        = err_q;
   assign line_rdata = line_q;
   assign bus_req    = bus_req_q;
   assign bus_rwn    = rwn_q;
   assign bus_addr   = addr_q & 16'hFFF0;
   assign bus_wdata  = buf_q[MP_BEAT_W*cnt_q +: MP_BEAT_W];

endmodule

// File: tb/tb_mp_mem_arbiter.sv
// Scoreboard bench for mp_mem_arbiter: stimulus pushes expected completions,
// commands and write beats; a negedge monitor pops and compares them.
module tb_mp_mem_arbiter;

   localparam int TO = 255;

   logic         sys_clk = 1'b0;
   logic         sys_rst_n = 1'b0;
   logic         ic_req, ic_done, dc_req, dc_rwn, dc_done, err;
   logic [15:0]  ic_addr, dc_addr, bus_addr;
   logic [127:0] dc_wdata, line_rdata;
   logic         bus_req, bus_gnt, bus_rwn, bus_beat;
   logic [31:0]  bus_wdata, bus_rdata;

   int cyc = 0;
   int n_pass = 0;
   int n_tot = 0;

   typedef struct {
      bit           own;
      bit           err;
      bit           chk_line;
      logic [127:0] line;
      int           cyc;
   } exp_t;

   typedef struct {
      logic [15:0] addr;
      bit          rwn;
   } cmd_t;

   exp_t        eq[$];
   cmd_t        cq[$];
   logic [31:0] wq[$];

   mp_mem_arbiter #(.BEATS(4), .TIMEOUT(TO)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .ic_req     (ic_req),
      .ic_addr    (ic_addr),
      .ic_done    (ic_done),
      .dc_req     (dc_req),
      .dc_rwn     (dc_rwn),
      .dc_addr    (dc_addr),
      .dc_wdata   (dc_wdata),
      .dc_done    (dc_done),
      .line_rdata (line_rdata),
      .err        (err),
      .bus_req    (bus_req),
      .bus_gnt    (bus_gnt),
      .bus_rwn    (bus_rwn),
      .bus_addr   (bus_addr),
      .bus_beat   (bus_beat),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_tot++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", nm, act, req);
   endtask

   function automatic logic [127:0] rr_line(input int j);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[32*i +: 32] = 32'h1000 * (j + 1) + 32'(i);
      return l;
   endfunction

   // Monitor: pops and compares whenever the DUT presents something.
   always @(negedge sys_clk) begin
      exp_t e;
      cmd_t c;
      if (sys_rst_n) begin
         if (ic_done || dc_done) begin
            chk("one_done", 128'(ic_done & dc_done), 128'(0));
            if (eq.size() == 0) begin
               n_tot++;
               $display("FAIL unexpected_done: actual ic=%0b dc=%0b required none", ic_done, dc_done);
            end else begin
               e = eq.pop_front();
               chk("done_owner", 128'(dc_done), 128'(e.own));
               chk("done_err", 128'(err), 128'(e.err));
               if (e.chk_line) chk("line_rdata", line_rdata, e.line);
               if (e.cyc >= 0) chk("done_cycle", 128'(cyc), 128'(e.cyc));
            end
         end
         if (bus_req && bus_gnt) begin
            if (cq.size() == 0) begin
               n_tot++;
               $display("FAIL unexpected_cmd: actual addr %0h required none", bus_addr);
            end else begin
               c = cq.pop_front();
               chk("bus_addr", 128'(bus_addr), 128'(c.addr));
               chk("bus_rwn", 128'(bus_rwn), 128'(c.rwn));
            end
         end
         if (bus_beat && wq.size() > 0) chk("bus_wdata", 128'(bus_wdata), 128'(wq.pop_front()));
      end
   end

   task automatic wait_req();
      int n = 0;
      do begin
         @(posedge sys_clk); #1;
         n++;
      end while (!bus_req && n < 20);
      chk("bus_req_seen", 128'(bus_req), 128'(1));
   endtask

   task automatic slave_beats(input logic [127:0] rd, input int gap);
      @(posedge sys_clk); #1;
      bus_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_beat  = 1'b1;
         bus_rdata = rd[32*i +: 32];
         @(posedge sys_clk); #1;
         bus_beat = 1'b0;
         if (i < 3) repeat (gap) begin @(posedge sys_clk); #1; end
      end
   endtask

   // One transaction from an idle arbiter; own 0 = I$, 1 = D$.
   task automatic run(input bit own, input bit rwn, input logic [15:0] addr,
                      input logic [127:0] wd, input logic [127:0] rd,
                      input int gap, input bit gnt_en);
      exp_t e;
      int   n;
      e.own      = own;
      e.err      = !gnt_en;
      e.chk_line = rwn || !gnt_en;
      e.line     = gnt_en ? rd : 128'(0);
      e.cyc      = gnt_en ? cyc + 6 + 3 * gap : cyc + TO + 2;
      eq.push_back(e);
      if (gnt_en) cq.push_back('{addr & 16'hFFF0, rwn});
      if (gnt_en && !rwn) for (int i = 0; i < 4; i++) wq.push_back(wd[32*i +: 32]);
      bus_gnt = gnt_en;
      if (own) begin
         dc_req = 1'b1; dc_rwn = rwn; dc_addr = addr; dc_wdata = wd;
      end else begin
         ic_req = 1'b1; ic_addr = addr;
      end
      if (gnt_en) begin
         wait_req();
         slave_beats(rd, gap);
      end else begin
         n = 0;
         do begin
            @(posedge sys_clk); #1;
            n++;
         end while (!(ic_done || dc_done) && n < TO + 10);
         chk("timeout_done_seen", 128'(ic_done | dc_done), 128'(1));
      end
      ic_req = 1'b0; dc_req = 1'b0; dc_wdata = '0;
      @(posedge sys_clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: actual cycle %0d required finish", cyc);
      $fatal(1, "bench timed out");
   end

   initial begin
      exp_t e;
      ic_req = 1'b1; dc_req = 1'b1; dc_rwn = 1'b1;
      ic_addr = 16'h1000; dc_addr = 16'h2008; dc_wdata = '0;
      bus_gnt = 1'b1; bus_beat = 1'b0; bus_rdata = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_bus_req", 128'(bus_req), 128'(0));
      chk("rst_ic_done", 128'(ic_done), 128'(0));
      chk("rst_dc_done", 128'(dc_done), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_line", line_rdata, 128'(0));

      // Both held from reset: I$, D$, I$, D$.
      for (int j = 0; j < 4; j++) begin
         e.own = (j % 2 == 1); e.err = 1'b0; e.chk_line = 1'b1;
         e.line = rr_line(j); e.cyc = -1;
         eq.push_back(e);
         cq.push_back('{(j % 2 == 1) ? 16'h2000 : 16'h1000, 1'b1});
      end
      sys_rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         bus_gnt = 1'b1;
         wait_req();
         slave_beats(rr_line(j), 0);
      end
      ic_req = 1'b0; dc_req = 1'b0;
      repeat (2) begin @(posedge sys_clk); #1; end

      run(1'b0, 1'b1, 16'h1234, '0, 128'h000000A3_000000A2_000000A1_000000A0, 0, 1'b1);
      run(1'b1, 1'b0, 16'h5678, 128'h44444444_33333333_22222222_11111111, '0, 0, 1'b1);
      run(1'b0, 1'b1, 16'h00FF, '0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 3, 1'b1);
      run(1'b1, 1'b1, 16'hABCD, '0, 128'h0F0F0F0F_F0F0F0F0_12121212_34343434, 0, 1'b1);

      // Watchdog, then a normal transaction afterwards.
      run(1'b0, 1'b1, 16'h4444, '0, '0, 0, 1'b0);
      run(1'b1, 1'b1, 16'h9ABC, '0, 128'h55555555_66666666_77777777_88888888, 0, 1'b1);

      // Reset while beat 2 is on the bus: abandoned with no done.
      cq.push_back('{16'h0BE0, 1'b1});
      ic_req = 1'b1; ic_addr = 16'h0BEE; bus_gnt = 1'b1;
      wait_req();
      @(posedge sys_clk); #1;
      bus_gnt = 1'b0; bus_beat = 1'b1; bus_rdata = 32'h0;
      repeat (2) begin @(posedge sys_clk); #1; end
      bus_rdata = 32'h2;
      #2 sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_bus_req", 128'(bus_req), 128'(0));
      chk("mid_rst_ic_done", 128'(ic_done), 128'(0));
      chk("mid_rst_dc_done", 128'(dc_done), 128'(0));
      ic_req = 1'b0; bus_beat = 1'b0;
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;
      run(1'b0, 1'b1, 16'h7777, '0, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 0, 1'b1);

      repeat (3) begin @(posedge sys_clk); #1; end
      chk("done_queue_empty", 128'(eq.size()), 128'(0));
      chk("cmd_queue_empty", 128'(cq.size()), 128'(0));
      chk("wdata_queue_empty", 128'(wq.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
